// File: rtl/cpu_pkg.sv
// Shared CPU types and word/byte helpers used by the data memory.
package cpu_pkg;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 16;

  typedef logic [15:0] word_t;
  typedef logic [7:0]  byte_t;

  // Big-endian split: the high byte sits at the lower address.
  function automatic byte_t hi_byte(input word_t w);
    return w[15:8];
  endfunction

  function automatic byte_t lo_byte(input word_t w);
    return w[7:0];
  endfunction

  function automatic word_t join_bytes(input byte_t hi, input byte_t lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/data_memory.sv
// Byte-addressed, big-endian data memory for the MEM stage of the 16-bit CPU.
// Words occupy two consecutive byte cells; unaligned addresses are legal and
// overlapping words share bytes. Writes are synchronous, reads combinational.
module data_memory #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH_BYTES = 128
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] adresa,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              MemWrite,
  input  logic              MemRead,
  output logic [DATA_W-1:0] ReadData
);

  import cpu_pkg::*;

  localparam int IDX_W = $clog2(DEPTH_BYTES);

  byte_t             mem [DEPTH_BYTES];
  logic [ADDR_W:0]   addr_end;
  logic              addr_ok;
  logic [IDX_W-1:0]  idx_hi;
  logic [IDX_W-1:0]  idx_lo;

  // The second byte's address is computed one bit wider so that 16'hFFFF
  // cannot wrap around to a small in-range value.
  assign addr_end = {1'b0, adresa} + (ADDR_W+1)'(1);
  assign addr_ok  = (addr_end < (ADDR_W+1)'(DEPTH_BYTES));

  // Cell indices are only used when addr_ok holds, so truncation is harmless.
  assign idx_hi = adresa[IDX_W-1:0];
  assign idx_lo = idx_hi + IDX_W'(1);

  // Byte array: reset clears every cell; a valid write stores both bytes.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH_BYTES; i++) begin
        mem[i] <= '0;
      end
    end else if (MemWrite && addr_ok) begin
      mem[idx_hi] <= hi_byte(WriteData);
      mem[idx_lo] <= lo_byte(WriteData);
    end
  end

  // Read mux: zero unless reading a valid address outside of reset.
  always_comb begin
    ReadData = '0;
    if (!Reset && MemRead && addr_ok) begin
      ReadData = join_bytes(mem[idx_hi], mem[idx_lo]);
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: a vector table applied through a
// scoreboard queue, followed by hand-written multi-cycle corner cases.
module tb_data_memory;

  logic        Clock;
  logic        Reset;
  logic [15:0] adresa;
  logic [15:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [15:0] ReadData;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        we;
    logic        re;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t        vq[$];
  logic [15:0] sb[$];

  data_memory #(.DATA_W(16), .ADDR_W(16), .DEPTH_BYTES(128)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .adresa   (adresa),
    .WriteData(WriteData),
    .MemWrite (MemWrite),
    .MemRead  (MemRead),
    .ReadData (ReadData)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic we, input logic re, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [15:0] exp, input string name);
    vec_t v;
    v.we = we; v.re = re; v.addr = addr; v.wdata = wdata; v.exp = exp; v.name = name;
    vq.push_back(v);
  endtask

  // Drive on the falling edge, compare ReadData just after (before the write edge).
  task automatic apply(input vec_t v);
    logic [15:0] e;
    @(negedge Clock);
    adresa    = v.addr;
    WriteData = v.wdata;
    MemWrite  = v.we;
    MemRead   = v.re;
    sb.push_back(v.exp);
    #1;
    e = sb.pop_front();
    check(v.name, ReadData, e);
  endtask

  initial begin
    Reset = 1'b1; adresa = '0; WriteData = '0; MemWrite = 1'b0; MemRead = 1'b1;
    #1;
    check("read_in_reset", ReadData, 16'h0000);
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;

    //     we    re    addr      wdata     exp (before edge)
    add_vec(1'b0, 1'b1, 16'd0,    16'h0000, 16'h0000, "rst_rd0");
    add_vec(1'b0, 1'b1, 16'd14,   16'h0000, 16'h0000, "rst_rd14");
    add_vec(1'b0, 1'b1, 16'd126,  16'h0000, 16'h0000, "rst_rd126");
    add_vec(1'b1, 1'b0, 16'd14,   16'd21,   16'h0000, "wr14_21");
    add_vec(1'b0, 1'b1, 16'd14,   16'h0000, 16'h0015, "rd14_21");
    add_vec(1'b1, 1'b0, 16'd14,   16'hABCD, 16'h0000, "wr14_abcd");
    add_vec(1'b0, 1'b0, 16'd14,   16'h0000, 16'h0000, "rd14_gated");
    add_vec(1'b0, 1'b1, 16'd14,   16'h0000, 16'hABCD, "rd14_abcd");
    add_vec(1'b1, 1'b0, 16'd14,   16'h1234, 16'h0000, "wr14_1234");
    add_vec(1'b1, 1'b1, 16'd15,   16'h5678, 16'h3400, "wr15_old");
    add_vec(1'b0, 1'b1, 16'd14,   16'h0000, 16'h1256, "rd14_overlap");
    add_vec(1'b0, 1'b1, 16'd15,   16'h0000, 16'h5678, "rd15");
    add_vec(1'b1, 1'b1, 16'd127,  16'hFFFF, 16'h0000, "wr127_bad");
    add_vec(1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, "wrffff_bad");
    add_vec(1'b0, 1'b1, 16'd126,  16'h0000, 16'h0000, "rd126_clean");
    add_vec(1'b0, 1'b1, 16'd0,    16'h0000, 16'h0000, "rd0_clean");
    add_vec(1'b1, 1'b0, 16'd126,  16'h0102, 16'h0000, "wr126");
    add_vec(1'b0, 1'b1, 16'd126,  16'h0000, 16'h0102, "rd126");
    add_vec(1'b0, 1'b1, 16'd125,  16'h0000, 16'h0001, "rd125");
    add_vec(1'b0, 1'b1, 16'd127,  16'h0000, 16'h0000, "rd127_bad");
    add_vec(1'b0, 1'b1, 16'd128,  16'h0000, 16'h0000, "rd128_bad");

    foreach (vq[i]) begin
      apply(vq[i]);
      if (vq[i].name == "rd14_21") begin
        check("mem14", {8'h00, dut.mem[14]}, 16'h0000);
        check("mem15", {8'h00, dut.mem[15]}, 16'h0015);
      end
    end

    // Untouched cells around the dropped writes stay zero.
    check("mem0_clean",  {8'h00, dut.mem[0]},  16'h0000);
    check("mem1_clean",  {8'h00, dut.mem[1]},  16'h0000);
    check("mem127",      {8'h00, dut.mem[127]}, 16'h0002);

    // Read and write at the same address: old word until the edge, new after.
    @(negedge Clock);
    adresa = 16'd40; WriteData = 16'h1111; MemWrite = 1'b1; MemRead = 1'b1;
    @(negedge Clock);
    WriteData = 16'h2222;
    #1 check("rw_same_before", ReadData, 16'h1111);
    @(posedge Clock);
    #1 check("rw_same_after", ReadData, 16'h2222);

    // MemWrite pulsed only between edges never takes effect.
    @(negedge Clock);
    MemWrite = 1'b0; WriteData = 16'h3333;
    #1 MemWrite = 1'b1;
    #1 MemWrite = 1'b0;
    @(posedge Clock);
    #1 check("glitch_no_write", ReadData, 16'h2222);

    // Asynchronous reset between edges clears memory and output at once.
    @(negedge Clock);
    adresa = 16'd2; WriteData = 16'h00AA; MemWrite = 1'b1; MemRead = 1'b1;
    @(negedge Clock);
    MemWrite = 1'b0;
    #1 check("rd2_aa", ReadData, 16'h00AA);
    #1 Reset = 1'b1;
    #1 check("async_rst_out", ReadData, 16'h0000);
    check("async_rst_mem3", {8'h00, dut.mem[3]}, 16'h0000);
    // X on MemWrite during reset must not write anything.
    MemWrite = 1'bx; WriteData = 16'hBEEF;
    @(posedge Clock);
    #1 Reset = 1'b0; MemWrite = 1'b0;
    #1 check("rd2_after_rst", ReadData, 16'h0000);
    adresa = 16'd40;
    #1 check("rd40_after_rst", ReadData, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
